// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// one-hot size encodings and size-to-byte/lane conversions.
package dmem_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  // Byte count of a one-hot size; 0 for any illegal encoding.
  function automatic logic [3:0] size_bytes(input logic [3:0] size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      SZ_D:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [3:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      SZ_D:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory port: request and response valid/ready handshakes.
// master = pipeline (initiator), slave = dmem_responder.
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [63:0]       req_addr;
  logic [3:0]        req_size;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_byte_array.sv
// Byte-addressed storage with 8 lanes: per-lane synchronous write and a
// combinational 8-byte read, both at an arbitrary (wrapping) base address.
module dmem_byte_array #(
  parameter  int DEPTH_BYTES = 1024,
  localparam int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [7:0]    we,
  input  logic [AW-1:0] base,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // NOTE: storage has no reset branch; clearing every byte would force a
  // flop-based array and its contents are undefined until written anyway.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (we[k]) mem[base + AW'(k)] <= wdata[8*k +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = mem[base + AW'(k)];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency,
// size/range checks. Define DMEM_ALIGN_CHECK_EN to also reject unaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input logic    clk,
  input logic    reset,
  dmem_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               accept, commit;

  logic               wr_q;
  logic [63:0]        addr_q;
  logic [3:0]         size_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;

  logic [3:0]         bytes;
  logic [64:0]        end_addr;
  logic               misalign;
  logic               err_now;
  logic [7:0]         mask;
  logic [7:0]         we;
  logic [DATA_W-1:0]  bit_mask;
  logic [DATA_W-1:0]  rd_raw;
  logic [DATA_W-1:0]  rd_masked;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (commit) begin
        rdata_q <= (wr_q || err_now) ? '0 : rd_masked;
        err_q   <= err_now;
      end else if (state == RESP && bus.resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Request fields are only meaningful between accept and commit.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= bus.req_write;
      addr_q  <= bus.req_addr;
      size_q  <= bus.req_size;
      wdata_q <= bus.req_wdata;
    end
  end

  // Range check in 65 bits so a carry out of addr+size counts as out of range.
  assign bytes    = size_bytes(size_q);
  assign end_addr = {1'b0, addr_q} + 65'(bytes);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (addr_q[2:0] & (bytes[2:0] - 3'd1)) != 3'd0;
`else
  assign misalign = 1'b0;
`endif

  assign err_now = !$onehot(size_q) || (end_addr > 65'(DEPTH_BYTES)) || misalign;

  assign mask = lane_mask(size_q);
  // A reset sampled on the commit edge drops the store.
  assign we   = (commit && wr_q && !err_now && !reset) ? mask : 8'h00;

  always_comb begin
    bit_mask = '0;
    for (int k = 0; k < 8; k++) begin
      bit_mask[8*k +: 8] = {8{mask[k]}};
    end
  end

  assign rd_masked = rd_raw & bit_mask;

  dmem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .base  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (rd_raw)
  );

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_BYTES=1024, LATENCY=2); honours
// DMEM_ALIGN_CHECK_EN for the unaligned-load expectation.
module tb_dmem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_BYTES(1024),
    .LATENCY    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present a request while req_ready is high; returns #1 after the accept edge.
  task automatic send(input logic w, input logic [63:0] addr, input logic [3:0] size,
                      input logic [63:0] wdata);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  task automatic wait_resp(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
    end while (!bus.resp_valid && edges < 20);
    if (!bus.resp_valid) check("resp_valid_timeout", 64'(bus.resp_valid), 64'd1);
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic w, input logic [63:0] addr,
                      input logic [3:0] size, input logic [63:0] wdata,
                      input logic [63:0] exp_rdata, input logic exp_err);
    int edges;
    send(w, addr, size, wdata);
    wait_resp(edges);
    check({tag, "_lat"},   64'(edges), 64'd2);
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, "_err"},   64'(bus.resp_err), 64'(exp_err));
    ack();
    check({tag, "_ready_after"}, 64'(bus.req_ready), 64'd1);
    check({tag, "_valid_after"}, 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    int edges;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  64'(bus.req_ready),  64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", bus.resp_rdata,      64'd0);
    check("rst_resp_err",   64'(bus.resp_err),   64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full-width store/load and byte merge
    xact("st_d_10", 1'b1, 64'h10, 4'b1000, 64'h1122334455667788, 64'h0, 1'b0);
    xact("ld_d_10", 1'b0, 64'h10, 4'b1000, 64'h0, 64'h1122334455667788, 1'b0);
    xact("st_b_12", 1'b1, 64'h12, 4'b0001, 64'hDEADBEEFCAFE00FF, 64'h0, 1'b0);
    xact("ld_d_10b", 1'b0, 64'h10, 4'b1000, 64'h0, 64'h1122334455FF7788, 1'b0);
    xact("ld_h_12", 1'b0, 64'h12, 4'b0010, 64'h0, 64'h00000000000055FF, 1'b0);
    xact("ld_b_17", 1'b0, 64'h17, 4'b0001, 64'h0, 64'h0000000000000011, 1'b0);

    // Range boundary: last 8 bytes are legal, straddling the end is not
    xact("st_d_3f8", 1'b1, 64'h3F8, 4'b1000, 64'h0102030405060708, 64'h0, 1'b0);
    xact("st_d_3fc", 1'b1, 64'h3FC, 4'b1000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
    xact("ld_d_3f8", 1'b0, 64'h3F8, 4'b1000, 64'h0, 64'h0102030405060708, 1'b0);
    xact("ld_wrap",  1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 4'b1000, 64'h0, 64'h0, 1'b1);
    xact("ld_3ff_h", 1'b0, 64'h3FF, 4'b0010, 64'h0, 64'h0, 1'b1);

    // Illegal size with response back-pressure
    send(1'b0, 64'h10, 4'b0011, 64'h0);
    wait_resp(edges);
    check("bad_sz_lat", 64'(edges), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(bus.resp_valid), 64'd1);
      check("hold_rdata", bus.resp_rdata,      64'd0);
      check("hold_err",   64'(bus.resp_err),   64'd1);
      check("hold_ready", 64'(bus.req_ready),  64'd0);
      @(posedge clk); #1;
    end
    ack();
    xact("sz_zero", 1'b0, 64'h10, 4'b0000, 64'h0, 64'h0, 1'b1);

    // Unaligned word load
    xact("st_d_20", 1'b1, 64'h20, 4'b1000, 64'h8877665544332211, 64'h0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    xact("ld_w_21", 1'b0, 64'h21, 4'b0100, 64'h0, 64'h0, 1'b1);
`else
    xact("ld_w_21", 1'b0, 64'h21, 4'b0100, 64'h0, 64'h0000000055443322, 1'b0);
`endif

    // Reset before the commit edge drops the store
    xact("st_d_40", 1'b1, 64'h40, 4'b1000, 64'h0123456789ABCDEF, 64'h0, 1'b0);
    send(1'b1, 64'h40, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req_ready",  64'(bus.req_ready),  64'd1);
    check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("mid_rst_resp_rdata", bus.resp_rdata,      64'd0);
    check("mid_rst_resp_err",   64'(bus.resp_err),   64'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(bus.resp_valid), 64'd0);
    xact("ld_d_40", 1'b0, 64'h40, 4'b1000, 64'h0, 64'h0123456789ABCDEF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory port: accepts one load/store request at a time over a valid/ready handshake, performs the access after a configurable latency, and returns read data and an error flag over a response handshake. It replaces the fixed single-cycle data memory in the MEM stage when a stall-capable pipeline is used; the pipeline acts as initiator and this block is the responder.

## Interface
- DEPTH_BYTES, 1024: storage size in bytes; power of two, ≥ 8.
- LATENCY, 2: clock edges from request acceptance to access/response; ≥ 1.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_size  in  4  transfer size, one-hot: 4'b0001 = 1 B, 4'b0010 = 2 B, 4'b0100 = 4 B, 4'b1000 = 8 B
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts response
- resp_rdata  out  64  load data, zero-extended; 0 for stores and errors
- resp_err  out  1  request was rejected, no access performed

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready, latch write/addr/size/wdata, load countdown with LATENCY-1, go to WAIT.
- WAIT: req_ready = 0. Countdown decrements each edge. At the edge where it is 0, perform the access, latch the result, go to RESP.
- RESP: resp_valid = 1; resp_rdata/resp_err stable. On resp_ready, go to IDLE. No new request is accepted in the same cycle; req_ready rises the cycle after the response handshake.
- Exactly one request is outstanding. Inputs other than resp_ready are ignored outside IDLE.
- Little-endian: byte k of the data maps to address req_addr+k.
- Stores write only size bytes; the other bytes in storage are unchanged. Loads return size bytes in bits [8·size-1:0] and zeros above.
- Error conditions (resp_err = 1, storage unchanged, resp_rdata = 0):
  - req_size not one-hot, including 0.
  - req_addr + size > DEPTH_BYTES. The comparison uses full 64-bit width, and carry is treated as out of range, so there is no wrap-around.
- Reset clears state to IDLE and the countdown to 0. Storage contents are not reset.
- Reset during WAIT drops the request. A store is not committed unless its commit edge has already passed.
- Reset during RESP discards the response.

## Timing
- Reset values: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Accept edge is E0. Access and commit happen at edge E_LATENCY. resp_valid is high from E_LATENCY until the edge where resp_ready is sampled high.
- Minimum request-to-request spacing is LATENCY + 2 cycles.
- Outputs are registered; there is no combinational path from req_* or resp_ready to any output.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: a request whose req_addr is not a multiple of its size is an error, with the error behaviour above.
- DMEM_ALIGN_CHECK_EN not defined: unaligned accesses are performed normally, byte by byte, subject only to the size and range checks.

## Structure
- Package dmem_pkg holds:
  - FSM state enum.
  - Size encoding constants SZ_B, SZ_H, SZ_W, SZ_D.
  - DATA_W = 64.
  - Function to convert one-hot size to byte count.
- Sub-module dmem_byte_array holds the storage:
  - Byte-addressed, 8 lanes.
  - Per-lane write enable; write on clk.
  - Combinational 8-byte read at an arbitrary base address.
  - The top level handles FSM, checks, lane masking, and zero-extension.

## Test plan
- LATENCY=2. Store addr 0x10, size 8, data 0x1122334455667788, then load addr 0x10, size 8 → resp_rdata 0x1122334455667788, resp_err 0. resp_valid rises exactly 2 edges after each accept.
- After the above, store addr 0x12, size 1, data 0xFF; load addr 0x10, size 8 → 0x11223344 55FF7788. Load addr 0x12, size 2 → 0x0000_0000_0000_55FF.
- Store addr 0x3FC, size 8 (DEPTH_BYTES = 1024) → resp_err 1. A load at 0x3F8, size 8 shows the prior contents unchanged. Address 0xFFFF_FFFF_FFFF_FFFC, size 8 → resp_err 1.
- req_size 4'b0011 or 4'b0000 → resp_err 1, resp_rdata 0. Hold resp_ready = 0 for 5 cycles → resp_valid and data held stable, req_ready stays 0.
- Load addr 0x21, size 4:
  - With DMEM_ALIGN_CHECK_EN → resp_err 1.
  - Without it → correct 4 bytes, resp_err 0.
- Accept a store to 0x40, assert reset 1 cycle later (before the commit edge) → outputs return to reset values next edge. A following load at 0x40 returns the old contents.
